// File: rtl/router_pkg.sv
// Shared types and helpers for the data-router bank scheduling logic.
//   bank_t        : 2-bit bank index (drives the router's bank-select mux)
//   sched_state_t : frame sequencing states of the bank scheduler
//   MAX_BANKS     : largest bank count a 2-bit select can address
//   wrap_inc      : modulo-n increment of a bank index
package router_pkg;

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

    localparam int MAX_BANKS = 4;

    function automatic bank_t wrap_inc(input bank_t p, input int n);
        if (int'(p) >= n - 1) begin
            return '0;
        end
        return p + bank_t'(1);
    endfunction

endpackage

// File: rtl/bank_ptr.sv
// Wrap-around bank pointer register.
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : force the pointer back to bank 0
//   inc_i    : advance the pointer, wrapping from N-1 to 0
//   ptr_o    : current bank index
module bank_ptr
    import router_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  inc_i,
    output bank_t ptr_o
);

    bank_t ptr_q;
    bank_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = wrap_inc(ptr_q, int'(N));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bank_scheduler.sv
// Rotating row-bank scheduler for the data router.
// Tracks POY row banks: the writer fills the bank at wr_bank when wr_ready,
// the PE array reads the head bank selected by rd_bank when rd_valid. Each
// bank is read eff_reuse times before it is freed; the frame ends once
// cfg_rows banks have been released.
//   clk, rst            : clock, synchronous active-high reset
//   start               : frame start pulse (only honoured in IDLE)
//   cfg_rows, cfg_reuse : frame length in bank fills, read passes per bank
//   wr_ready, wr_bank   : free bank available / bank to fill
//   wr_done             : writer finished filling wr_bank
//   rd_valid, rd_bank   : head bank readable / mux bank select
//   rd_done             : reader finished one pass over rd_bank
//   occupancy           : number of full banks
//   busy, frame_done    : not idle / one-cycle end-of-frame pulse
//   err                 : sticky flag for ignored wr_done/rd_done pulses
// POY must lie in 2..MAX_BANKS since the bank select is 2 bits wide.
module bank_scheduler
    import router_pkg::*;
#(
    parameter int unsigned POY  = 3,
    parameter int unsigned ROWW = 16,
    parameter int unsigned RW   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ROWW-1:0]            cfg_rows,
    input  logic [RW-1:0]              cfg_reuse,
    output logic                       wr_ready,
    output bank_t                      wr_bank,
    input  logic                       wr_done,
    output logic                       rd_valid,
    output bank_t                      rd_bank,
    input  logic                       rd_done,
    output logic [$clog2(POY+1)-1:0]   occupancy,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       err
);

    localparam int unsigned OCCW = $clog2(POY + 1);
    localparam logic [OCCW-1:0] POY_OCC = OCCW'(POY);

    sched_state_t    state_q, state_d;
    logic [ROWW-1:0] cfg_rows_q, cfg_rows_d;
    logic [RW-1:0]   eff_reuse_q, eff_reuse_d;
    logic [OCCW-1:0] occ_q, occ_d;
    logic [RW-1:0]   reuse_cnt_q, reuse_cnt_d;
    logic [ROWW-1:0] rows_wr_q, rows_wr_d;
    logic [ROWW-1:0] rows_rd_q, rows_rd_d;
    logic            err_q, err_d;

    logic start_acc;
    logic wr_acc;
    logic rd_acc;
    logic rel_evt;

    assign wr_ready = (state_q == RUN) && (occ_q < POY_OCC) && (rows_wr_q < cfg_rows_q);
    assign rd_valid = (state_q == RUN) && (occ_q != '0);

    assign start_acc = (state_q == IDLE) && start;
    assign wr_acc    = wr_done && wr_ready;
    assign rd_acc    = rd_done && rd_valid;
    // The final read pass of the head bank frees it.
    assign rel_evt   = rd_acc && (reuse_cnt_q >= eff_reuse_q - RW'(1));

    always_comb begin
        state_d     = state_q;
        cfg_rows_d  = cfg_rows_q;
        eff_reuse_d = eff_reuse_q;
        occ_d       = occ_q;
        reuse_cnt_d = reuse_cnt_q;
        rows_wr_d   = rows_wr_q;
        rows_rd_d   = rows_rd_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_rows_d  = cfg_rows;
                    eff_reuse_d = (cfg_reuse == '0) ? RW'(1) : cfg_reuse;
                    occ_d       = '0;
                    reuse_cnt_d = '0;
                    rows_wr_d   = '0;
                    rows_rd_d   = '0;
                    state_d     = (cfg_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // rows_rd reaches cfg_rows only on a release; leave a cycle later.
                if (rows_rd_q == cfg_rows_q) begin
                    state_d = DONE;
                end
                if (wr_acc) begin
                    rows_wr_d = rows_wr_q + ROWW'(1);
                end
                if (rel_evt) begin
                    reuse_cnt_d = '0;
                    rows_rd_d   = rows_rd_q + ROWW'(1);
                end else if (rd_acc) begin
                    reuse_cnt_d = reuse_cnt_q + RW'(1);
                end
                unique case ({wr_acc, rel_evt})
                    2'b10:   occ_d = occ_q + OCCW'(1);
                    2'b01:   occ_d = occ_q - OCCW'(1);
                    default: occ_d = occ_q;
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start in IDLE clears err even if a stray pulse arrives with it.
        if (start_acc) begin
            err_d = 1'b0;
        end else if ((wr_done && !wr_acc) || (rd_done && !rd_acc)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_rows_q  <= '0;
            eff_reuse_q <= '0;
            occ_q       <= '0;
            reuse_cnt_q <= '0;
            rows_wr_q   <= '0;
            rows_rd_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_rows_q  <= cfg_rows_d;
            eff_reuse_q <= eff_reuse_d;
            occ_q       <= occ_d;
            reuse_cnt_q <= reuse_cnt_d;
            rows_wr_q   <= rows_wr_d;
            rows_rd_q   <= rows_rd_d;
            err_q       <= err_d;
        end
    end

    bank_ptr #(.N(POY)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_acc),
        .inc_i (wr_acc),
        .ptr_o (wr_bank)
    );

    bank_ptr #(.N(POY)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_acc),
        .inc_i (rel_evt),
        .ptr_o (rd_bank)
    );

    assign occupancy  = occ_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_bank_scheduler.sv
// Self-checking bench for bank_scheduler (POY=3). A frame-level reference
// model (row counts, reuse count, phase) predicts every output each cycle;
// directed sequences add explicit expectations for the key scenarios.
module tb_bank_scheduler;

    localparam int POY = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_rows;
    logic [7:0]  cfg_reuse;
    logic        wr_ready;
    logic [1:0]  wr_bank;
    logic        wr_done;
    logic        rd_valid;
    logic [1:0]  rd_bank;
    logic        rd_done;
    logic [1:0]  occupancy;
    logic        busy;
    logic        frame_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: banks are handed out in order, so both pointers are
    // simply the write/release counts modulo POY and occupancy is their difference.
    int m_state   = M_IDLE;
    int m_rows    = 0;
    int m_reuse   = 1;
    int m_cnt     = 0;
    int m_rows_wr = 0;
    int m_rows_rd = 0;
    int m_err     = 0;

    bank_scheduler #(.POY(POY), .ROWW(16), .RW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_rows   (cfg_rows),
        .cfg_reuse  (cfg_reuse),
        .wr_ready   (wr_ready),
        .wr_bank    (wr_bank),
        .wr_done    (wr_done),
        .rd_valid   (rd_valid),
        .rd_bank    (rd_bank),
        .rd_done    (rd_done),
        .occupancy  (occupancy),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_occ();
        return m_rows_wr - m_rows_rd;
    endfunction

    function automatic int m_wr_ready();
        return int'(m_state == M_RUN && m_occ() < POY && m_rows_wr < m_rows);
    endfunction

    function automatic int m_rd_valid();
        return int'(m_state == M_RUN && m_occ() > 0);
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input bit rs, input bit s, input bit w, input bit r);
        int wacc;
        int racc;
        if (rs) begin
            m_state = M_IDLE; m_rows = 0; m_reuse = 1; m_cnt = 0;
            m_rows_wr = 0; m_rows_rd = 0; m_err = 0;
            return;
        end
        wacc = int'(w) & m_wr_ready();
        racc = int'(r) & m_rd_valid();
        if (m_state == M_IDLE && s) begin
            m_err = 0;
        end else if ((w && wacc == 0) || (r && racc == 0)) begin
            m_err = 1;
        end
        case (m_state)
            M_IDLE: if (s) begin
                m_rows    = int'(cfg_rows);
                m_reuse   = (cfg_reuse == 0) ? 1 : int'(cfg_reuse);
                m_cnt     = 0;
                m_rows_wr = 0;
                m_rows_rd = 0;
                m_state   = (m_rows == 0) ? M_DONE : M_RUN;
            end
            M_RUN: begin
                if (m_rows_rd == m_rows) m_state = M_DONE;
                if (wacc != 0) m_rows_wr++;
                if (racc != 0) begin
                    if (m_cnt + 1 >= m_reuse) begin
                        m_cnt = 0;
                        m_rows_rd++;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk_eq("wr_ready",   int'(wr_ready),   m_wr_ready());
        chk_eq("rd_valid",   int'(rd_valid),   m_rd_valid());
        chk_eq("wr_bank",    int'(wr_bank),    m_rows_wr % POY);
        chk_eq("rd_bank",    int'(rd_bank),    m_rows_rd % POY);
        chk_eq("occupancy",  int'(occupancy),  m_occ());
        chk_eq("busy",       int'(busy),       int'(m_state != M_IDLE));
        chk_eq("frame_done", int'(frame_done), int'(m_state == M_DONE));
        chk_eq("err",        int'(err),        m_err);
    endtask

    // One clock cycle: hold the given inputs across the edge, then compare.
    task automatic cyc(input bit rs, input bit s, input bit w, input bit r);
        rst = rs; start = s; wr_done = w; rd_done = r;
        @(posedge clk);
        model_step(rs, s, w, r);
        #1;
        rst = 1'b0; start = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        check_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_wr_ready"}, int'(wr_ready), 0);
        chk_eq({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk_eq({tag, "_wr_bank"},  int'(wr_bank), 0);
        chk_eq({tag, "_rd_bank"},  int'(rd_bank), 0);
        chk_eq({tag, "_occ"},      int'(occupancy), 0);
        chk_eq({tag, "_busy"},     int'(busy), 0);
        chk_eq({tag, "_fdone"},    int'(frame_done), 0);
        chk_eq({tag, "_err"},      int'(err), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        cfg_rows = '0; cfg_reuse = '0;

        // Reset state
        cyc(1, 0, 0, 0);
        chk_all_zero("reset");

        // Basic flow: 4 rows, single pass each
        cfg_rows = 16'd4; cfg_reuse = 8'd1;
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk_eq("basic_wr_bank", int'(wr_bank), i % 3);
            cyc(0, 0, 1, 0);
            chk_eq("basic_rd_valid", int'(rd_valid), 1);
            chk_eq("basic_rd_bank", int'(rd_bank), i % 3);
            cyc(0, 0, 0, 1);
        end
        chk_eq("basic_fdone_early", int'(frame_done), 0);
        cyc(0, 0, 0, 0);
        chk_eq("basic_fdone", int'(frame_done), 1);
        cyc(0, 0, 0, 0);
        chk_eq("basic_busy_after", int'(busy), 0);
        chk_eq("basic_fdone_after", int'(frame_done), 0);

        // Full: 3 fills, then an overflowing 4th
        cfg_rows = 16'd5; cfg_reuse = 8'd1;
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk_eq("full_occ", int'(occupancy), 3);
        chk_eq("full_wr_ready", int'(wr_ready), 0);
        cyc(0, 0, 1, 0);
        chk_eq("full_occ_after", int'(occupancy), 3);
        chk_eq("full_wr_bank", int'(wr_bank), 0);
        chk_eq("full_err", int'(err), 1);

        // Reuse of 3 passes, then simultaneous write + release
        cyc(1, 0, 0, 0);
        cfg_rows = 16'd4; cfg_reuse = 8'd3;
        cyc(0, 1, 0, 0);
        chk_eq("start_clears_err", int'(err), 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk_eq("reuse_bank_p1", int'(rd_bank), 0);
        cyc(0, 0, 0, 1);
        chk_eq("reuse_bank_p2", int'(rd_bank), 0);
        cyc(0, 0, 0, 1);
        chk_eq("reuse_bank_p3", int'(rd_bank), 1);
        chk_eq("reuse_occ", int'(occupancy), 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk_eq("simul_occ_before", int'(occupancy), 2);
        cyc(0, 0, 1, 1);
        chk_eq("simul_occ", int'(occupancy), 2);
        chk_eq("simul_wr_bank", int'(wr_bank), 1);
        chk_eq("simul_rd_bank", int'(rd_bank), 2);

        // Reset mid-frame with occupancy 2 and one pass done on the head bank
        cyc(0, 0, 0, 1);
        chk_eq("midrst_occ", int'(occupancy), 2);
        cyc(1, 0, 0, 0);
        chk_all_zero("midrst");
        cfg_rows = 16'd1; cfg_reuse = 8'd1;
        cyc(0, 1, 0, 0);
        chk_eq("clean_wr_bank", int'(wr_bank), 0);
        cyc(0, 0, 1, 0);
        chk_eq("clean_rd_bank", int'(rd_bank), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk_eq("clean_fdone", int'(frame_done), 1);
        cyc(0, 0, 0, 0);

        // cfg_rows = 0: straight to DONE, then IDLE
        cfg_rows = 16'd0; cfg_reuse = 8'd2;
        cyc(0, 1, 0, 0);
        chk_eq("zrows_fdone", int'(frame_done), 1);
        chk_eq("zrows_wr_ready", int'(wr_ready), 0);
        cyc(0, 0, 0, 0);
        chk_eq("zrows_fdone_after", int'(frame_done), 0);
        chk_eq("zrows_busy_after", int'(busy), 0);

        // cfg_reuse = 0 behaves as a single pass
        cfg_rows = 16'd2; cfg_reuse = 8'd0;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk_eq("zreuse_occ", int'(occupancy), 0);
        chk_eq("zreuse_rd_bank", int'(rd_bank), 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk_eq("zreuse_fdone", int'(frame_done), 1);
        cyc(0, 0, 0, 0);

        // Randomised traffic, including stray pulses, restarts and resets
        for (int n = 0; n < 4000; n++) begin
            bit rs, s, w, r;
            cfg_rows  = 16'($urandom_range(0, 7));
            cfg_reuse = 8'($urandom_range(0, 3));
            rs = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 3) == 0);
            w  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 1) == 1);
            cyc(rs, s, w, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
